// File: rtl/fsm_input_sched.sv
// ============================================================================
// Module      : fsm_input_sched
// Description : Round-robin scheduler that shares the FSM's 2-bit input among
//               N_REQ requesters, issuing one code followed by GAP idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_input_sched #(
    parameter int N_REQ = 4,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] code,
    output logic [N_REQ-1:0]   ack,
    output logic [1:0]         fsm_in,
    output logic               fsm_valid,
    output logic               busy,
    output logic [7:0]         issue_cnt
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_ptr, w_ptr_nxt;
    logic [3:0]           r_gap, w_gap_nxt;
    logic [N_REQ-1:0]     w_ack_nxt;
    logic [1:0]           w_fsm_in_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_arb_ok;
    logic                 w_win_found;
    logic [c_idx_w-1:0]   w_win_idx;
    logic [1:0]           w_win_code;

    // Search upward from the slot after the last grant, wrapping around.
    always_comb begin : p_arb
        int                 j;
        logic [c_idx_w-1:0] jj;
        j           = 0;
        jj          = '0;
        w_win_found = 1'b0;
        w_win_idx   = r_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            j  = (int'(r_ptr) + k) % N_REQ;
            jj = c_idx_w'(j);
            if (!w_win_found && req[jj]) begin
                w_win_found = 1'b1;
                w_win_idx   = jj;
            end
        end
        w_win_code = code[{w_win_idx, 1'b0} +: 2];
    end

    always_comb begin : p_next
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gap_nxt    = r_gap;
        w_ack_nxt    = '0;
        w_fsm_in_nxt = 2'b00;
        w_valid_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_cnt_nxt    = issue_cnt;
        w_arb_ok     = 1'b0;
        case (r_state)
            S_IDLE: w_arb_ok = 1'b1;
            S_ISSUE: begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = 4'(GAP);
                w_busy_nxt  = 1'b1;
            end
            S_GAP: begin
                if (r_gap == 4'd1) begin
                    w_arb_ok = 1'b1;
                end else begin
                    w_gap_nxt  = r_gap - 4'd1;
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Outputs are produced one edge ahead so the code lands with ack.
        if (w_arb_ok) begin
            if (en && w_win_found) begin
                w_state_nxt           = S_ISSUE;
                w_ptr_nxt             = w_win_idx;
                w_ack_nxt[w_win_idx]  = 1'b1;
                w_fsm_in_nxt          = w_win_code;
                w_valid_nxt           = 1'b1;
                w_busy_nxt            = 1'b1;
                if (w_win_code != 2'b00) begin
                    w_cnt_nxt = issue_cnt + 8'd1;
                end
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_idx_w'(N_REQ - 1);
            r_gap     <= '0;
            ack       <= '0;
            fsm_in    <= 2'b00;
            fsm_valid <= 1'b0;
            busy      <= 1'b0;
            issue_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gap     <= w_gap_nxt;
            ack       <= w_ack_nxt;
            fsm_in    <= w_fsm_in_nxt;
            fsm_valid <= w_valid_nxt;
            busy      <= w_busy_nxt;
            issue_cnt <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_input_sched.sv
// ============================================================================
// Module      : tb_fsm_input_sched
// Description : Vector table, directed corner sequences and a randomized run
//               against a cycle-count reference model of fsm_input_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_input_sched;

    localparam int N   = 4;
    localparam int GAP = 1;

    logic           clk;
    logic           reset;
    logic           en;
    logic [N-1:0]   req;
    logic [2*N-1:0] code;
    logic [N-1:0]   ack;
    logic [1:0]     fsm_in;
    logic           fsm_valid;
    logic           busy;
    logic [7:0]     issue_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fsm_input_sched #(.N_REQ(N), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .code      (code),
        .ack       (ack),
        .fsm_in    (fsm_in),
        .fsm_valid (fsm_valid),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [3:0]   req;
        logic [7:0]   code;
        logic [3:0]   ack;
        logic [1:0]   fin;
        logic         val;
        logic         busy;
        logic [7:0]   cnt;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input string field, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] e_ack, input logic [1:0] e_fin,
                           input logic e_val, input logic e_busy, input logic [7:0] e_cnt);
        chk(name, "ack", int'(ack), int'(e_ack));
        chk(name, "fsm_in", int'(fsm_in), int'(e_fin));
        chk(name, "fsm_valid", int'(fsm_valid), int'(e_val));
        chk(name, "busy", int'(busy), int'(e_busy));
        chk(name, "issue_cnt", int'(issue_cnt), int'(e_cnt));
    endtask

    task automatic drive(input logic r, input logic e, input logic [N-1:0] rq, input logic [2*N-1:0] cd);
        reset = r;
        en    = e;
        req   = rq;
        code  = cd;
        @(posedge clk);
        #1;
    endtask

    // Reference model: grants are spaced by cycle arithmetic, not by states.
    int           m_ptr;
    int           m_last;
    int           m_cnt;
    int           m_cyc;
    logic [3:0]   e_ack;
    logic [1:0]   e_fin;
    logic         e_val;
    logic         e_busy;

    task automatic model_step(input logic r, input logic e, input logic [N-1:0] rq, input logic [2*N-1:0] cd);
        int win;
        int j;
        win = -1;
        if (!r) begin
            m_ptr  = N - 1;
            m_last = -1000;
            m_cnt  = 0;
            e_ack  = '0;
            e_fin  = 2'b00;
            e_val  = 1'b0;
            e_busy = 1'b0;
        end else begin
            if (e && (m_cyc - m_last) >= GAP + 1) begin
                for (int k = 1; k <= N; k++) begin
                    j = (m_ptr + k) % N;
                    if (win < 0 && rq[j]) win = j;
                end
            end
            if (win >= 0) begin
                e_ack  = 4'(1 << win);
                e_fin  = cd[2*win +: 2];
                e_val  = 1'b1;
                e_busy = 1'b1;
                if (e_fin != 2'b00) m_cnt = (m_cnt + 1) % 256;
                m_ptr  = win;
                m_last = m_cyc;
            end else begin
                e_ack  = '0;
                e_fin  = 2'b00;
                e_val  = 1'b0;
                e_busy = ((m_cyc - m_last) <= GAP);
            end
        end
        m_cyc++;
    endtask

    initial begin
        logic [N-1:0]   pend;
        logic [1:0]     cd [N];
        logic [2*N-1:0] cvec;
        logic           r_in;
        logic           e_in;

        reset = 1'b0; en = 1'b1; req = '0; code = '0;

        // Reset values, single request, reset, four simultaneous requests.
        tv[0]  = '{1'b0, 1'b1, 4'b1111, 8'hFF,        4'b0000, 2'b00, 1'b0, 1'b0, 8'd0};
        tv[1]  = '{1'b0, 1'b1, 4'b1111, 8'hFF,        4'b0000, 2'b00, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{1'b1, 1'b1, 4'b0100, 8'b00100000,  4'b0100, 2'b10, 1'b1, 1'b1, 8'd1};
        tv[3]  = '{1'b1, 1'b1, 4'b0000, 8'b00000000,  4'b0000, 2'b00, 1'b0, 1'b1, 8'd1};
        tv[4]  = '{1'b1, 1'b1, 4'b0000, 8'b00000000,  4'b0000, 2'b00, 1'b0, 1'b0, 8'd1};
        tv[5]  = '{1'b0, 1'b1, 4'b0000, 8'b00000000,  4'b0000, 2'b00, 1'b0, 1'b0, 8'd0};
        tv[6]  = '{1'b1, 1'b1, 4'b1111, 8'b01111001,  4'b0001, 2'b01, 1'b1, 1'b1, 8'd1};
        tv[7]  = '{1'b1, 1'b1, 4'b1110, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b1, 8'd1};
        tv[8]  = '{1'b1, 1'b1, 4'b1110, 8'b01111001,  4'b0010, 2'b10, 1'b1, 1'b1, 8'd2};
        tv[9]  = '{1'b1, 1'b1, 4'b1100, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b1, 8'd2};
        tv[10] = '{1'b1, 1'b1, 4'b1100, 8'b01111001,  4'b0100, 2'b11, 1'b1, 1'b1, 8'd3};
        tv[11] = '{1'b1, 1'b1, 4'b1000, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b1, 8'd3};
        tv[12] = '{1'b1, 1'b1, 4'b1000, 8'b01111001,  4'b1000, 2'b01, 1'b1, 1'b1, 8'd4};
        tv[13] = '{1'b1, 1'b1, 4'b0000, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b1, 8'd4};
        tv[14] = '{1'b1, 1'b1, 4'b0000, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b0, 8'd4};
        tv[15] = '{1'b1, 1'b0, 4'b1111, 8'b01111001,  4'b0000, 2'b00, 1'b0, 1'b0, 8'd4};

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].req, tv[i].code);
            chk_all($sformatf("vec%0d", i), tv[i].ack, tv[i].fin, tv[i].val, tv[i].busy, tv[i].cnt);
        end

        // Fairness: requesters 0 and 3 held high alternate.
        drive(1'b0, 1'b1, 4'b0000, 8'h00);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 4'b1001, 8'b11000001);
            if (k % 2 == 0) begin
                chk("fair", "ack", int'(ack), ((k / 2) % 2 == 0) ? 1 : 8);
                chk("fair", "fsm_in", int'(fsm_in), ((k / 2) % 2 == 0) ? 1 : 3);
            end else begin
                chk("fair_gap", "fsm_in", int'(fsm_in), 0);
                chk("fair_gap", "busy", int'(busy), 1);
            end
        end

        // Null code is acked but not counted; en low blocks grants.
        drive(1'b0, 1'b1, 4'b0000, 8'h00);
        drive(1'b1, 1'b1, 4'b0010, 8'b00000000);
        chk_all("null_issue", 4'b0010, 2'b00, 1'b1, 1'b1, 8'd0);
        drive(1'b1, 1'b1, 4'b0000, 8'h00);
        chk_all("null_gap", 4'b0000, 2'b00, 1'b0, 1'b1, 8'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'b0001, 8'b00000001);
            chk_all("en_low", 4'b0000, 2'b00, 1'b0, 1'b0, 8'd0);
        end
        drive(1'b1, 1'b1, 4'b0001, 8'b00000001);
        chk_all("en_back", 4'b0001, 2'b01, 1'b1, 1'b1, 8'd1);
        drive(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("mid_gap", "busy", int'(busy), 1);
        drive(1'b0, 1'b1, 4'b0000, 8'h00);
        chk_all("reset_in_gap", 4'b0000, 2'b00, 1'b0, 1'b0, 8'd0);

        // Counter wrap after 256 nonzero issues.
        for (int g = 1; g <= 256; g++) begin
            drive(1'b1, 1'b1, 4'b0001, 8'b00000001);
            if (g == 255) chk("wrap", "cnt255", int'(issue_cnt), 255);
            if (g == 256) chk("wrap", "cnt0", int'(issue_cnt), 0);
            drive(1'b1, 1'b1, 4'b0001, 8'b00000001);
        end

        // Randomized requesters obeying the hold-until-ack rule.
        m_cyc = 0;
        pend  = '0;
        for (int i = 0; i < N; i++) cd[i] = 2'b00;
        model_step(1'b0, 1'b1, '0, '0);
        drive(1'b0, 1'b1, '0, '0);
        chk_all("rnd_rst", e_ack, e_fin, e_val, e_busy, 8'(m_cnt));
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    pend[i] = ($urandom_range(0, 2) == 0);
                    if (pend[i]) cd[i] = 2'($urandom_range(0, 3));
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    cd[i]   = 2'($urandom_range(0, 3));
                end
            end
            for (int i = 0; i < N; i++) cvec[2*i +: 2] = cd[i];
            r_in = ($urandom_range(0, 199) != 0);
            e_in = ($urandom_range(0, 7) != 0);
            model_step(r_in, e_in, pend, cvec);
            drive(r_in, e_in, pend, cvec);
            chk_all("rnd", e_ack, e_fin, e_val, e_busy, 8'(m_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsm_input_sched.md
# fsm_input_sched

Round-robin scheduler that shares the 2-bit input of the lab-10 code-driven FSM among up to `N_REQ` requesters. Each requester posts a 2-bit code; the scheduler grants one requester at a time, drives that code onto the FSM input for exactly one cycle, then drives `2'b00` for `GAP` idle cycles. This produces the code / `00` / code cadence the FSM expects. It sits directly in front of the FSM's `in` port and replaces ad-hoc stimulus generation.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `GAP`, 1, idle (`00`) cycles inserted after every issued code (1..15).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  grant enable; when low, no new grant is made and an in-flight issue/gap completes.
- `req`  in  N_REQ  per-requester request, level.
- `code`  in  2*N_REQ  per-requester code; requester i uses `code[2i+1:2i]`.
- `ack`  out  N_REQ  one-hot, one-cycle pulse; the granted code is on `fsm_in` this cycle.
- `fsm_in`  out  2  drives the FSM `in` port.
- `fsm_valid`  out  1  high in the issue cycle only.
- `busy`  out  1  high in ISSUE and GAP states.
- `issue_cnt`  out  8  count of nonzero codes issued; wraps.

## Operation
- All outputs are registered.
- **States:** IDLE, ISSUE, GAP.
- **Arbitration point:** arbitration happens in IDLE and in the final GAP cycle, when `en`=1 and `req` is not all zero.
  - The winner is the first set `req` bit searching from `ptr+1` upward, wrapping modulo `N_REQ`.
  - `ptr` is the index of the last grant; its reset value is `N_REQ-1`, so requester 0 has first priority after reset.
- **On grant:**
  - Latch the winner's code and index, and set `ptr` to the winner.
  - Next state is ISSUE.
  - Code changes after the grant edge have no effect.
- **ISSUE (1 cycle):** `fsm_in`=latched code, `fsm_valid`=1, `ack[winner]`=1, `busy`=1.
  - `issue_cnt` increments if the latched code ≠ `00`.
  - A code-`00` request is still granted, acked and followed by a gap, but is not counted.
  - Next state is GAP, with the gap counter loaded to `GAP`.
- **GAP (`GAP` cycles):** `fsm_in`=`00`, `fsm_valid`=0, `ack`=0, `busy`=1.
  - The final GAP cycle arbitrates. On a grant, the next state is ISSUE (back-to-back); otherwise the next state is IDLE.
- **IDLE:** `fsm_in`=`00`, `fsm_valid`=0, `ack`=0, `busy`=0.
- **Requester rule:** hold `req` and `code` stable until `ack`, and drive `req` low in the cycle after `ack` unless posting a new request.
- **Simultaneous requests:** resolved purely by the round-robin order; no requester waits more than `N_REQ-1` grants.
- **`en` low:** blocks grants in IDLE and in the final GAP cycle. An ISSUE already scheduled still completes.
- **`issue_cnt`:** 8-bit, wraps 255 → 0.
- **Reset (`reset`=0 at an edge), including mid-ISSUE or mid-GAP:**
  - State goes to IDLE; `fsm_in`=`00`; `fsm_valid`=0; `ack`=0; `busy`=0; `issue_cnt`=0; `ptr`=`N_REQ-1`.
  - A grant latched but not yet acked is discarded, so its requester keeps `req` high and is re-arbitrated.

## Timing
- Request latency: `req` high in IDLE at cycle t → `ack` and the code on `fsm_in` at t+1.
- Throughput: one code every `GAP+1` cycles under continuous load. With `GAP`=1: code, `00`, code, `00`, …
- A request arriving during ISSUE or a non-final GAP cycle is first considered in the final GAP cycle.
- `busy` falls in the cycle after the final GAP cycle only if no grant was made.
- Reset takes effect at the first edge with `reset`=0. The first grant can occur at the first edge with `reset`=1.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles with `req`=`1111` → `fsm_in`=`00`, `fsm_valid`=0, `ack`=`0000`, `busy`=0, `issue_cnt`=0 throughout.
- **Single request:** `req`=`0100`, `code[5:4]`=`10` at t → at t+1 `ack`=`0100`, `fsm_in`=`10`, `fsm_valid`=1; at t+2 `fsm_in`=`00`, `busy`=1; at t+3 `busy`=0; `issue_cnt`=1.
- **Four simultaneous requests:** `req`=`1111`, codes 01/10/11/01, each requester dropping `req` after its `ack` → `ack` order 0, 1, 2, 3 and `fsm_in` sequence 01, 00, 10, 00, 11, 00, 01, 00 with no extra idle cycles; `issue_cnt`=4.
- **Fairness:** `req[0]` and `req[3]` held high continuously with codes 01 and 11 → grants alternate 0, 3, 0, 3; `fsm_in` alternates 01, 00, 11, 00.
- **Null code:** a code-`00` request is acked with a gap and `issue_cnt` is unchanged. With `en`=0, pending requests get no `ack` until `en` returns to 1.
- **Reset mid-operation and wrap:** reset asserted in a GAP cycle → IDLE and the reset values at the next edge; the counter preloaded by 255 nonzero issues reads 0 after the 256th.
